timer_sched: RTL and testbench
==============================

# timer_sched

Four-channel periodic event scheduler for the single-cycle CPU's FPGA top level. A shared prescaler drives four independently reloadable down-counters, which replace the single free-running delay timer. Expired channels latch a pending flag. A round-robin arbiter presents one pending channel at a time to the CPU through an input port, and the CPU acknowledges it through an output port.

## Interface
- PRE_W, 10: prescaler width; base tick period = 2^PRE_W clk cycles
- CNT_W, 16: channel reload/counter width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  2  channel addressed by cfg_we
- cfg_reload  in  CNT_W  reload value R
- cfg_run  in  1  1 = arm channel, 0 = stop channel
- ack  in  1  acknowledge of currently granted channel, one cycle
- tick  out  4  per-channel single-cycle expiry pulse
- pending  out  4  latched expiry flags
- irq_valid  out  1  at least one pending flag set
- irq_ch  out  2  granted channel, valid when irq_valid
- overrun  out  4  sticky "expired while still pending" flags

## Operation
- Prescaler: PRE_W-bit free-running up-counter. base_tick = 1 in the cycle the prescaler equals all-ones, then it wraps to 0.
- Per channel: run bit, reload register, CNT_W-bit count.
- Config write (cfg_we = 1): reload[cfg_ch] and count[cfg_ch] load cfg_reload; run[cfg_ch] loads cfg_run. pending and overrun of that channel are unchanged.
- Running channel on base_tick: if count = 0, the channel expires: tick = 1, count reloads R, pending set. Otherwise count decrements.
- Period is (R+1) base ticks. R = 0 expires on every base tick.
- Stopped channels hold count and never expire.
- Arbiter: a 2-bit round-robin pointer ptr, reset 0. irq_ch is the first set pending bit searching ptr, ptr+1, … mod 4. This is combinational from registered state. irq_valid = |pending.
- ack with irq_valid = 1: clears pending[irq_ch] and overrun[irq_ch]; ptr = irq_ch + 1 mod 4.
- ack with irq_valid = 0: ignored; ptr unchanged.
- Simultaneous events:
  - Config write to a channel in the same cycle as its expiry: the write wins; no tick, no pending set.
  - ack of a channel in the same cycle as its new expiry: pending stays 1. With overrun enabled, overrun is not set (the old event was consumed).
  - Several channels expiring together: all set pending; the arbiter serialises them.
- Reset mid-operation clears everything immediately: prescaler, counts, reloads, run, pending, overrun, ptr. No tick is emitted.

## Timing
- Reset values: tick = 0, pending = 0, irq_valid = 0, irq_ch = 0, overrun = 0.
- Config write at edge N, base_tick first seen after N: expiry at the (R+1)-th base_tick after N.
- tick is asserted combinationally in the expiry cycle (base_tick && run && count==0 && !write-to-that-channel). pending is visible from the next edge.
- irq_valid/irq_ch follow pending with zero additional latency.
- ack takes effect at the edge that samples it; the next grant is visible one cycle later.

## Configuration
- TIMER_SCHED_OVERRUN_EN defined:
  - overrun[i] sets when channel i expires while pending[i] = 1 and no ack clears it that cycle.
  - It clears on ack of channel i or on reset.
- Not defined: overrun is tied to 4'b0000 and the detection logic is absent. All other behaviour is identical.

## Test plan
- Reset mid-count, PRE_W = 2: assert reset with ch0 running, R = 3 → all outputs 0 next cycle; no tick for 40 cycles after release until reconfigured.
- Period, PRE_W = 2: write ch1, R = 2, run = 1 → tick[1] every 12 clk cycles; pending[1] = 1, irq_ch = 1 one cycle after the first tick.
- Round robin: ch0 and ch2 pending, ptr = 0 → irq_ch = 0; ack → irq_ch = 2; ack → irq_valid = 0, ptr = 3.
- Write/expiry collision: write ch3 (R = 5) in the exact ch3 expiry cycle → no tick[3]; next expiry 6 base ticks later.
- Overrun (macro on): ch0 R = 0 with no ack for 2 base ticks → overrun[0] = 1; ack → pending[0] = 0, overrun[0] = 0. Macro off → overrun stays 0.
- Ack/expiry collision: ack ch0 in its expiry cycle → pending[0] remains 1, overrun[0] = 0.

Source files
------------

// File: rtl/timer_sched_if.sv
// Bus between the CPU ports and timer_sched: channel configuration,
// acknowledge, and the expiry/interrupt status returned to the CPU.
interface timer_sched_if #(
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_reload;
  logic             cfg_run;
  logic             ack;
  logic [3:0]       tick;
  logic [3:0]       pending;
  logic             irq_valid;
  logic [1:0]       irq_ch;
  logic [3:0]       overrun;

  // CPU side
  modport master (
    output cfg_we, cfg_ch, cfg_reload, cfg_run, ack,
    input  tick, pending, irq_valid, irq_ch, overrun
  );

  // Scheduler side
  modport slave (
    input  cfg_we, cfg_ch, cfg_reload, cfg_run, ack,
    output tick, pending, irq_valid, irq_ch, overrun
  );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: four-channel periodic event scheduler.
// A shared prescaler produces base_tick every 2^PRE_W cycles; each channel
// is a reloadable down-counter that latches a pending flag on expiry, and a
// round-robin arbiter presents one pending channel at a time to the CPU.
// Optional feature: define TIMER_SCHED_OVERRUN_EN to build sticky
// "expired while still pending" detection; otherwise overrun is tied to 0.

// One scheduler channel: run bit, reload register, counter, pending/overrun.
module timer_sched_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             base_tick,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_reload,
  input  logic             wr_run,
  input  logic             clr,
  output logic             tick,
  output logic             pending,
  output logic             overrun
);
  logic             run;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] count;

  // A config write to this channel suppresses an expiry in the same cycle.
  assign tick = base_tick && run && (count == '0) && !wr;

  // Config load, or count down on base_tick while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run    <= 1'b0;
      reload <= '0;
      count  <= '0;
    end else if (wr) begin
      run    <= wr_run;
      reload <= wr_reload;
      count  <= wr_reload;
    end else if (base_tick && run) begin
      count  <= (count == '0) ? reload : count - 1'b1;
    end
  end

  // A new expiry beats an ack in the same cycle, so the event is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pending <= 1'b0;
    else if (tick) pending <= 1'b1;
    else if (clr)  pending <= 1'b0;
  end

`ifdef TIMER_SCHED_OVERRUN_EN
  // Ack consumes the old event, so an expiry alongside an ack is no overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                overrun <= 1'b0;
    else if (clr)             overrun <= 1'b0;
    else if (tick && pending) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

module timer_sched #(
  parameter int PRE_W = 10,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  timer_sched_if.slave bus
);
  localparam int NUM_CH = 4;

  logic [PRE_W-1:0]  pre;
  logic              base_tick;
  logic [1:0]        ptr;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] ovr_w;
  logic [1:0]        grant;
  logic [1:0]        idx;
  logic              found;
  logic              take;

  assign base_tick = &pre;

  // Free-running prescaler; wraps from all-ones to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else       pre <= pre + 1'b1;
  end

  assign take = bus.ack && (|pend_w);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      timer_sched_ch #(.CNT_W(CNT_W)) u_ch (
        .clk       (clk),
        .reset     (reset),
        .base_tick (base_tick),
        .wr        (bus.cfg_we && (bus.cfg_ch == 2'(i))),
        .wr_reload (bus.cfg_reload),
        .wr_run    (bus.cfg_run),
        .clr       (take && (grant == 2'(i))),
        .tick      (tick_w[i]),
        .pending   (pend_w[i]),
        .overrun   (ovr_w[i])
      );
    end
  endgenerate

  // Round-robin search: first pending channel starting at ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!found && pend_w[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Advance the pointer past the channel just acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= '0;
    else if (take) ptr <= grant + 2'd1;
  end

  assign bus.tick      = tick_w;
  assign bus.pending   = pend_w;
  assign bus.irq_valid = |pend_w;
  assign bus.irq_ch    = grant;
  assign bus.overrun   = ovr_w;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with PRE_W = 2 (base tick every 4 cycles).
// After each reset release at edge P (cyc = 0), base_tick cycles start at
// edges P+3, P+7, P+11, ... so all expected times below are exact.
module tb_timer_sched;
  localparam int PRE_W = 2;
  localparam int CNT_W = 16;
`ifdef TIMER_SCHED_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   cnt;

  timer_sched_if #(.CNT_W(CNT_W)) bus ();

  timer_sched #(.PRE_W(PRE_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] r, input logic run);
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = ch;
    bus.cfg_reload = r;
    bus.cfg_run    = run;
    step();
    bus.cfg_we     = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_reload = '0;
    bus.cfg_run = 1'b0; bus.ack = 1'b0;

    // Reset values
    step(); step();
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_irq_valid", 32'(bus.irq_valid), 32'h0);
    check("rst_irq_ch", 32'(bus.irq_ch), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);

    // Reset mid-operation: ch0 R=3 expires on the 4th base tick (P+15)
    do_reset();
    cfg_write(2'd0, 16'd3, 1'b1);
    step_to(11);
    check("mid_no_early_tick", 32'(bus.tick), 32'h0);
    step_to(15);
    check("mid_tick0", 32'(bus.tick), 32'h1);
    step_to(16);
    check("mid_pending0", 32'(bus.pending), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_pending", 32'(bus.pending), 32'h0);
    check("mid_rst_irq_valid", 32'(bus.irq_valid), 32'h0);
    check("mid_rst_tick", 32'(bus.tick), 32'h0);
    step();
    reset = 1'b0;
    cyc = 0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.tick != 4'h0) cnt++;
    end
    check("post_rst_no_ticks", 32'(cnt), 32'd0);
    check("post_rst_pending", 32'(bus.pending), 32'h0);

    // Period: ch1 R=2 expires at P+11, then every 12 cycles
    do_reset();
    cfg_write(2'd1, 16'd2, 1'b1);
    step_to(7);
    check("per_no_tick_7", 32'(bus.tick), 32'h0);
    step_to(11);
    check("per_tick_11", 32'(bus.tick), 32'h2);
    check("per_pend_11", 32'(bus.pending), 32'h0);
    step_to(12);
    check("per_pend_12", 32'(bus.pending), 32'h2);
    check("per_irq_valid_12", 32'(bus.irq_valid), 32'h1);
    check("per_irq_ch_12", 32'(bus.irq_ch), 32'h1);
    step_to(22);
    check("per_no_tick_22", 32'(bus.tick), 32'h0);
    step_to(23);
    check("per_tick_23", 32'(bus.tick), 32'h2);
    step_to(24);
    check("per_overrun_24", 32'(bus.overrun), OVR ? 32'h2 : 32'h0);
    do_ack();
    check("per_ack_pending", 32'(bus.pending), 32'h0);
    check("per_ack_overrun", 32'(bus.overrun), 32'h0);
    check("per_ack_irq_valid", 32'(bus.irq_valid), 32'h0);
    step_to(35);
    check("per_tick_35", 32'(bus.tick), 32'h2);

    // Round robin: ch0 and ch2 expire together at P+3
    do_reset();
    cfg_write(2'd0, 16'd0, 1'b1);
    cfg_write(2'd2, 16'd0, 1'b1);
    step_to(3);
    check("rr_tick_both", 32'(bus.tick), 32'h5);
    step_to(4);
    check("rr_pending", 32'(bus.pending), 32'h5);
    check("rr_irq_ch0", 32'(bus.irq_ch), 32'h0);
    cfg_write(2'd0, 16'd0, 1'b0);
    cfg_write(2'd2, 16'd0, 1'b0);
    do_ack();
    check("rr_irq_ch2", 32'(bus.irq_ch), 32'h2);
    check("rr_pending_after1", 32'(bus.pending), 32'h4);
    do_ack();
    check("rr_irq_valid_off", 32'(bus.irq_valid), 32'h0);
    // ptr should now be 3: ch0 and ch3 pending must grant ch3 first
    cfg_write(2'd0, 16'd0, 1'b1);
    cfg_write(2'd3, 16'd0, 1'b1);
    step_to(12);
    check("rr_pending_03", 32'(bus.pending), 32'h9);
    check("rr_ptr3_grant", 32'(bus.irq_ch), 32'h3);
    cfg_write(2'd0, 16'd0, 1'b0);
    cfg_write(2'd3, 16'd0, 1'b0);
    do_ack();
    check("rr_wrap_grant0", 32'(bus.irq_ch), 32'h0);
    bus.ack = 1'b1;
    #1;
    step();
    bus.ack = 1'b0;
    check("rr_all_clear", 32'(bus.pending), 32'h0);
    // ack with nothing pending is ignored
    do_ack();
    check("rr_idle_ack", 32'(bus.irq_valid), 32'h0);

    // Write/expiry collision: ch3 R=1 would expire at P+7
    do_reset();
    cfg_write(2'd3, 16'd1, 1'b1);
    step_to(7);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd3; bus.cfg_reload = 16'd5; bus.cfg_run = 1'b1;
    #1;
    check("col_no_tick", 32'(bus.tick), 32'h0);
    step();
    bus.cfg_we = 1'b0;
    check("col_no_pending", 32'(bus.pending), 32'h0);
    cnt = 0;
    while (cyc < 30) begin
      step();
      if (bus.tick[3]) cnt++;
    end
    check("col_quiet", 32'(cnt), 32'd0);
    step_to(31);
    check("col_tick_31", 32'(bus.tick), 32'h8);

    // Overrun and ack/expiry collision: ch0 R=0 expires every base tick
    do_reset();
    cfg_write(2'd0, 16'd0, 1'b1);
    step_to(3);
    check("ovr_tick_3", 32'(bus.tick), 32'h1);
    step_to(4);
    check("ovr_pend_4", 32'(bus.pending), 32'h1);
    check("ovr_none_4", 32'(bus.overrun), 32'h0);
    step_to(8);
    check("ovr_set_8", 32'(bus.overrun), OVR ? 32'h1 : 32'h0);
    do_ack();
    check("ovr_ack_pending", 32'(bus.pending), 32'h0);
    check("ovr_ack_overrun", 32'(bus.overrun), 32'h0);
    step_to(12);
    check("ovr_pend_12", 32'(bus.pending), 32'h1);
    step_to(15);
    bus.ack = 1'b1;
    #1;
    check("ackcol_tick", 32'(bus.tick), 32'h1);
    step();
    bus.ack = 1'b0;
    check("ackcol_pending", 32'(bus.pending), 32'h1);
    check("ackcol_overrun", 32'(bus.overrun), 32'h0);
    cfg_write(2'd0, 16'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
